// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative write-through cache controller, per-set LRU, flush-all, single-outstanding memory port.
// Define CACHE_WRITE_ALLOC_EN to refill the victim line on a write miss; by default write misses go to memory only.
module cache_ctrl_2way #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 5,
    parameter int WORD_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TAG_W = ADDR_W - INDEX_W - WORD_W - 2;
    localparam int SETS  = 2 ** INDEX_W;
    localparam int LINE  = 2 ** WORD_W;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, REFILL_ISSUE, REFILL_WAIT, WRITE_WAIT, RESP, FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [WA_W-1:0]     addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic                victim_q, victim_d;
    logic                hit_flag_q, hit_flag_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0][SETS-1:0] valid_q, valid_d;
    logic [SETS-1:0]     lru_q, lru_d;
`ifdef CACHE_WRITE_ALLOC_EN
    logic                alloc_q, alloc_d;
`endif

    logic [TAG_W-1:0]    tag_ram  [2][SETS];
    logic [DATA_W-1:0]   data_ram [2][SETS*LINE];

    logic                       ram_we;
    logic                       ram_way;
    logic [INDEX_W+WORD_W-1:0]  ram_idx;
    logic [DATA_W-1:0]          ram_wdat;
    logic                       tag_we;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [WORD_W-1:0]   req_word;
    logic                hit0, hit1, hit_any, hit_way, victim_pick;
    logic [DATA_W-1:0]   rd0, rd1;
    logic                addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign req_tag  = addr_q[WA_W-1 -: TAG_W];
    assign req_idx  = addr_q[WORD_W +: INDEX_W];
    assign req_word = addr_q[WORD_W-1:0];

    assign hit0    = valid_q[0][req_idx] && (tag_ram[0][req_idx] == req_tag);
    assign hit1    = valid_q[1][req_idx] && (tag_ram[1][req_idx] == req_tag);
    assign hit_any = hit0 | hit1;
    assign hit_way = hit1;
    assign rd0     = data_ram[0][{req_idx, req_word}];
    assign rd1     = data_ram[1][{req_idx, req_word}];

    // Fill an empty way before evicting anything.
    assign victim_pick = !valid_q[0][req_idx] ? 1'b0 :
                         !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        victim_d   = victim_q;
        hit_flag_d = hit_flag_q;
        rdata_d    = rdata_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
`ifdef CACHE_WRITE_ALLOC_EN
        alloc_d    = alloc_q;
`endif
        ram_we     = 1'b0;
        ram_way    = 1'b0;
        ram_idx    = '0;
        ram_wdat   = '0;
        tag_we     = 1'b0;
        cpu_ready  = 1'b0;
        cpu_hit    = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (cpu_flush) begin
                    state_d = FLUSH;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr[ADDR_W-1:2];
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
`ifdef CACHE_WRITE_ALLOC_EN
                    alloc_d = 1'b0;
`endif
                    state_d = LOOKUP;
                end
            end
            FLUSH: begin
                valid_d   = '0;
                lru_d     = '0;
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            LOOKUP: begin
                if (!we_q) begin
                    if (hit_any) begin
                        cpu_ready        = 1'b1;
                        cpu_hit          = 1'b1;
                        cpu_rdata        = hit_way ? rd1 : rd0;
                        lru_d[req_idx]   = ~hit_way;
                        state_d          = IDLE;
                    end else begin
                        victim_d = victim_pick;
                        cnt_d    = '0;
                        state_d  = REFILL_ISSUE;
                    end
                end else begin
`ifdef CACHE_WRITE_ALLOC_EN
                    if (!hit_any && !alloc_q) begin
                        victim_d = victim_pick;
                        cnt_d    = '0;
                        alloc_d  = 1'b1;
                        state_d  = REFILL_ISSUE;
                    end else
`endif
                    if (mem_ready) begin
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = {addr_q, 2'b00};
                        mem_wdata = wdata_q;
`ifdef CACHE_WRITE_ALLOC_EN
                        // A line just allocated by this write still reports a miss.
                        hit_flag_d = hit_any & ~alloc_q;
`else
                        hit_flag_d = hit_any;
`endif
                        state_d    = WRITE_WAIT;
                        if (hit_any) begin
                            ram_we         = 1'b1;
                            ram_way        = hit_way;
                            ram_idx        = {req_idx, req_word};
                            ram_wdat       = wdata_q;
                            lru_d[req_idx] = ~hit_way;
                        end
                    end
                end
            end
            REFILL_ISSUE: begin
                if (mem_ready) begin
                    mem_req  = 1'b1;
                    mem_addr = {addr_q[WA_W-1:WORD_W], cnt_q, 2'b00};
                    state_d  = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem_done) begin
                    ram_we   = 1'b1;
                    ram_way  = victim_q;
                    ram_idx  = {req_idx, cnt_q};
                    ram_wdat = mem_rdata;
                    if (cnt_q == req_word) begin
                        rdata_d = mem_rdata;
                    end
                    // Tag and valid only change on the last word so a partial line never hits.
                    if (&cnt_q) begin
                        tag_we                     = 1'b1;
                        valid_d[victim_q][req_idx] = 1'b1;
                        lru_d[req_idx]             = ~victim_q;
`ifdef CACHE_WRITE_ALLOC_EN
                        state_d = we_q ? LOOKUP : RESP;
`else
                        state_d = RESP;
`endif
                    end else begin
                        cnt_d   = cnt_q + WORD_W'(1);
                        state_d = REFILL_ISSUE;
                    end
                end
            end
            WRITE_WAIT: begin
                if (mem_done) begin
                    cpu_ready = 1'b1;
                    cpu_hit   = hit_flag_q;
                    state_d   = IDLE;
                end
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            victim_q   <= 1'b0;
            hit_flag_q <= 1'b0;
            rdata_q    <= '0;
            valid_q    <= '0;
            lru_q      <= '0;
`ifdef CACHE_WRITE_ALLOC_EN
            alloc_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            victim_q   <= victim_d;
            hit_flag_q <= hit_flag_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            lru_q      <= lru_d;
`ifdef CACHE_WRITE_ALLOC_EN
            alloc_q    <= alloc_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            data_ram[ram_way][ram_idx] <= ram_wdat;
        end
        if (tag_we && !rst) begin
            tag_ram[victim_q][req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Bench for cache_ctrl_2way: directed scenarios then random traffic against a recency-list model of the cache.
`timescale 1ns/1ps
module tb_cache_ctrl_2way;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_flush;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_hit, busy;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready, mem_done;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cache_ctrl_2way dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    // Memory model: owns the backing store and the log of accepted requests.
    logic [31:0] mem_m [0:16383];
    mreq_t       mlog[$];
    int          viol = 0;
    int          stall_cycles = 0;
    int          log_base = 0;
    bit          stall_arm = 0;

    initial begin
        bit          pend;
        int          pend_cnt;
        logic        pwe;
        logic [13:0] pwaddr;
        pend = 0; pend_cnt = 0; pwe = 0; pwaddr = '0;
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        foreach (mem_m[i]) mem_m[i] = $urandom();
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = pwe ? $urandom() : mem_m[pwaddr];
                    pend      = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (!stall_arm) stall_cycles = 0;
            if (stall_arm && (mlog.size() - log_base) == 3 && stall_cycles < 5) begin
                mem_ready = 1'b0;
                stall_cycles++;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (mem_req === 1'b1) begin
                if (mem_ready !== 1'b1) viol++;
                mlog.push_back(mreq_t'{mem_we, mem_addr, mem_wdata});
                pend     = 1;
                pend_cnt = $urandom_range(0, 2);
                pwe      = mem_we;
                pwaddr   = mem_addr[15:2];
                if (mem_we) mem_m[mem_addr[15:2]] = mem_wdata;
            end
        end
    end

    // Cache model: resident lines as set*64+tag, most recently used first; at most two per set.
    int recent[$];

    function automatic int find_line(input int key);
        foreach (recent[i]) if (recent[i] == key) return i;
        return -1;
    endfunction

    task automatic touch(input int key);
        int idx;
        idx = find_line(key);
        if (idx >= 0) recent.delete(idx);
        recent.push_front(key);
    endtask

    task automatic insert_line(input int key);
        int n, last;
        n = 0; last = -1;
        foreach (recent[i]) if (recent[i] / 64 == key / 64) begin n++; last = i; end
        if (n == 2) recent.delete(last);
        recent.push_front(key);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(negedge clk); #2; n++; end
        if (n >= 400) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        chk("rst_ready", cpu_ready, 0);
        chk("rst_hit", cpu_hit, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        recent.delete();
    endtask

    task automatic do_op(input logic we, input logic [15:0] addr, input logic [31:0] wd);
        int          key, cyc;
        logic        exp_hit, seen;
        logic [31:0] exp_rd;
        logic [15:0] base;
        mreq_t       exp[$];
        mreq_t       got;
        wait_idle();
        key     = int'(addr[9:5]) * 64 + int'(addr[15:10]);
        exp_hit = (find_line(key) >= 0);
        exp_rd  = mem_m[addr[15:2]];
        base    = {addr[15:5], 5'b0};
        if (!we || (!exp_hit && `ifdef CACHE_WRITE_ALLOC_EN 1 `else 0 `endif)) begin
            if (exp_hit) touch(key);
            else begin
                for (int i = 0; i < 8; i++) exp.push_back(mreq_t'{1'b0, base + 16'(i * 4), 32'h0});
                insert_line(key);
            end
        end else if (exp_hit) begin
            touch(key);
        end
        if (we) exp.push_back(mreq_t'{1'b1, {addr[15:2], 2'b00}, wd});
        log_base = mlog.size();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk); #2;
        chk("busy_after_req", busy, 1);
        cyc = 1; seen = 0;
        while (cyc < 400) begin
            cpu_req = $urandom_range(0, 1); cpu_flush = ($urandom_range(0, 7) == 0);
            cpu_we = $urandom_range(0, 1); cpu_addr = 16'($urandom()); cpu_wdata = $urandom();
            if (cpu_ready === 1'b1) begin seen = 1; break; end
            @(negedge clk); #2; cyc++;
        end
        cpu_req = 1'b0; cpu_flush = 1'b0;
        chk("ready_seen", seen, 1);
        if (seen) begin
            chk("hit", cpu_hit, exp_hit);
            if (!we) chk("rdata", cpu_rdata, exp_rd);
            if (!we && exp_hit) chk("hit_latency", cyc, 1);
        end
        @(negedge clk); #2;
        chk("ready_one_cycle", cpu_ready, 0);
        chk("busy_after_done", busy, 0);
        chk("req_only_when_ready", viol, 0);
        chk("num_mem_req", mlog.size() - log_base, exp.size());
        for (int i = 0; i < exp.size() && (log_base + i) < mlog.size(); i++) begin
            got = mlog[log_base + i];
            chk("mem_we", got.we, exp[i].we);
            chk("mem_addr", got.addr, exp[i].addr);
            if (exp[i].we) chk("mem_wdata", got.wdata, exp[i].wdata);
        end
    endtask

    task automatic do_flush(input logic with_req);
        wait_idle();
        log_base = mlog.size();
        cpu_flush = 1'b1; cpu_req = with_req; cpu_we = 1'b0; cpu_addr = 16'h1234;
        @(negedge clk); #2;
        cpu_flush = 1'b0; cpu_req = 1'b0;
        chk("flush_ready", cpu_ready, 1);
        chk("flush_hit", cpu_hit, 0);
        @(negedge clk); #2;
        chk("flush_idle", busy, 0);
        chk("flush_no_mem", mlog.size() - log_base, 0);
        recent.delete();
    endtask

    initial begin
        int          n, rdy_cnt;
        logic [15:0] a;
        logic [5:0]  t6;
        logic [4:0]  s5;
        logic [2:0]  w3;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_flush = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        do_op(1'b0, 16'h1234, 32'h0);
        do_op(1'b0, 16'h1234, 32'h0);
        do_op(1'b0, 16'h5234, 32'h0);
        do_op(1'b0, 16'h1234, 32'h0);
        do_op(1'b0, 16'h9234, 32'h0);
        do_op(1'b0, 16'h1234, 32'h0);
        do_op(1'b0, 16'h5234, 32'h0);
        do_op(1'b1, 16'h1234, 32'hDEADBEEF);
        do_op(1'b0, 16'h1234, 32'h0);
        do_op(1'b1, 16'h2000, 32'hCAFEF00D);
        do_op(1'b0, 16'h2000, 32'h0);

        stall_arm = 1;
        do_op(1'b0, 16'h6000, 32'h0);
        chk("stall_cycles", stall_cycles, 5);
        stall_arm = 0;

        wait_idle();
        log_base = mlog.size();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        @(negedge clk); #2;
        cpu_req = 1'b0;
        n = 0;
        while ((mlog.size() - log_base) < 3 && n < 200) begin @(negedge clk); #2; n++; end
        chk("midrefill_reached", (mlog.size() - log_base) >= 3, 1);
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        rdy_cnt = 0;
        repeat (8) begin @(negedge clk); #2; if (cpu_ready === 1'b1 || busy === 1'b1) rdy_cnt++; end
        chk("midrst_quiet", rdy_cnt, 0);
        recent.delete();
        do_op(1'b0, 16'h4000, 32'h0);
        do_op(1'b0, 16'h1234, 32'h0);

        do_flush(1'b1);
        do_op(1'b0, 16'h1234, 32'h0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_flush($urandom_range(0, 1));
            end else begin
                t6 = 6'($urandom_range(0, 3));
                s5 = ($urandom_range(0, 1) != 0) ? 5'd17 : 5'd2;
                w3 = 3'($urandom_range(0, 7));
                a  = {t6, s5, w3, 2'b00};
                do_op(($urandom_range(0, 9) < 3), a, $urandom());
            end
        end

        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Parametrised successor to the direct-mapped write-through cache controller.
- 2-way set-associative, write-through, with per-set LRU replacement and parametrised index and line size.
- Sits between the CPU request port and the single-outstanding main-memory port (req/we/addr/wdata, ready/done/rdata).
- Contains its own tag, valid, LRU and data arrays, plus a flush-all command.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 32: word width. Byte offset is 2 bits.
- INDEX_W, 5: set index bits; SETS = 2**INDEX_W.
- WORD_W, 3: word-in-line bits; LINE = 2**WORD_W words.
- Derived: TAG_W = ADDR_W-INDEX_W-WORD_W-2. Must be ≥1.

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous active-high reset.
- cpu_req  in  1  Request. Sampled only in IDLE.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  Byte address. Fields: tag=[ADDR_W-1:ADDR_W-TAG_W], index, word, bits[1:0] ignored.
- cpu_wdata  in  DATA_W  Write data.
- cpu_flush  in  1  Invalidate all lines. Sampled only in IDLE.
- cpu_ready  out  1  One-cycle completion pulse.
- cpu_hit  out  1  Valid with cpu_ready: 1=hit.
- cpu_rdata  out  DATA_W  Read data. Valid with cpu_ready on reads.
- busy  out  1  High whenever state != IDLE.
- mem_req  out  1  Memory request. Asserted only when mem_ready=1.
- mem_we  out  1  Memory write.
- mem_addr  out  ADDR_W  Memory byte address. Word aligned.
- mem_wdata  out  DATA_W  Memory write data.
- mem_ready  in  1  Memory can accept a request.
- mem_done  in  1  One-cycle pulse: access complete; mem_rdata valid for reads.
- mem_rdata  in  DATA_W  Memory read data.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - All valid bits and LRU bits cleared.
  - Outputs: cpu_ready=0, cpu_hit=0, cpu_rdata=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-refill or mid-write aborts the operation; a late mem_done is ignored in IDLE.
- Request capture: in IDLE, cpu_req=1 registers addr, we and wdata. cpu_flush has priority over cpu_req in the same cycle.
- States: IDLE, LOOKUP, REFILL_ISSUE, REFILL_WAIT, WRITE_WAIT, RESP, FLUSH.
- IDLE:
  - cpu_flush → FLUSH.
  - cpu_req → LOOKUP.
- FLUSH: clear all valid and LRU bits in one cycle, pulse cpu_ready (cpu_hit=0), → IDLE.
- LOOKUP: compare the registered tag against both ways of the set; hit = valid & tag match.
  - Read hit: cpu_ready=1, cpu_hit=1, cpu_rdata=word from the hit way in this cycle. LRU := other way. → IDLE. Total latency 2 cycles from the cpu_req sample edge.
  - Read miss: pick victim (invalid way0 first, then invalid way1, else the LRU way); cnt:=0; → REFILL_ISSUE.
  - Write (hit or miss): drive a memory write to the captured addr/wdata. On hit, also write the hit way's word and set LRU := other way. → WRITE_WAIT.
- Memory write issue rule: mem_req is held until a cycle with mem_ready=1, in which the request is accepted. The FSM stays in place until then.
- REFILL_ISSUE: when mem_ready=1, drive mem_req=1, mem_we=0, mem_addr={tag,index,cnt,2'b00} for one cycle, → REFILL_WAIT.
- REFILL_WAIT, on mem_done:
  - Write mem_rdata into victim word cnt.
  - If cnt equals the requested word, capture it into the response register.
  - If cnt==LINE-1: write tag, set valid, LRU := other way, → RESP.
  - Else cnt++ → REFILL_ISSUE.
  - Tag and valid are not updated until the last word, so a partial line is never seen as a hit.
- RESP: cpu_ready=1, cpu_hit=0, cpu_rdata=captured word, → IDLE.
- WRITE_WAIT: on mem_done, cpu_ready=1, cpu_hit=stored hit flag, → IDLE.
- Write miss without allocate: the cache is unchanged.
- cnt wraps at LINE-1 only via the terminal test; no overflow.
- mem_done outside REFILL_WAIT/WRITE_WAIT is ignored.
- cpu_req and cpu_flush while busy are ignored and not queued.

Optional Feature:
- Macro: CACHE_WRITE_ALLOC_EN.
- Defined: a write miss first refills the victim line exactly as a read miss does. After the last word it writes cpu_wdata into the line, then performs the write-through and → WRITE_WAIT with cpu_hit=0.
- Undefined: write miss is a memory-only write (no-allocate).

Test Plan:
- Read 0x1234 after reset (tag=4, index=17, word=5) → 8 memory reads at 0x1220..0x123C in order. Response = data returned for 0x1234, hit=0. Re-read → ready 2 cycles after req, hit=1, same data, no mem_req.
- Read 0x1234, then 0x5234, then re-read 0x1234 (LRU=way1), then read 0x9234 → evicts the 0x5234 line. Read 0x1234 → hit. Read 0x5234 → miss.
- Write 0xDEADBEEF to 0x1234 on a hit → one mem write (addr 0x1234, data 0xDEADBEEF), ready on mem_done, hit=1. Read 0x1234 → hit, 0xDEADBEEF.
- Write miss to 0x2000 → one mem write, hit=0. Then read 0x2000: without the macro it misses and refills; with CACHE_WRITE_ALLOC_EN the write first does an 8-word refill and the read then hits with the written value.
- Hold mem_ready=0 for 5 cycles during refill → mem_req stays 0, no word is skipped. Assert rst in the middle of a refill → IDLE, busy=0, and a read to the same address misses.
- cpu_flush and cpu_req asserted together in IDLE → flush wins; the next read of a previously cached address misses.
